// File: rtl/riscv_wbu_regfile_if.sv
// Writeback/register-file bundle: ALU and LSU write sources, read ports,
// busy scoreboard and the commit observation signals.
interface riscv_wbu_regfile_if;
  logic        alu_wr_en;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        lsu_wr_vld;
  logic        lsu_wr_rdy;
  logic [4:0]  lsu_wr_addr;
  logic [31:0] lsu_wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        set_busy_en;
  logic [4:0]  set_busy_addr;
  logic [31:0] busy;
  logic        alu_stall;
  logic        commit_vld;
  logic        commit_src;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;

  modport master (
    output alu_wr_en, alu_wr_addr, alu_wr_data,
    output lsu_wr_vld, lsu_wr_addr, lsu_wr_data,
    output rs1_addr, rs2_addr, set_busy_en, set_busy_addr,
    input  lsu_wr_rdy, rs1_data, rs2_data, busy, alu_stall,
    input  commit_vld, commit_src, commit_addr, commit_data
  );

  modport slave (
    input  alu_wr_en, alu_wr_addr, alu_wr_data,
    input  lsu_wr_vld, lsu_wr_addr, lsu_wr_data,
    input  rs1_addr, rs2_addr, set_busy_en, set_busy_addr,
    output lsu_wr_rdy, rs1_data, rs2_data, busy, alu_stall,
    output commit_vld, commit_src, commit_addr, commit_data
  );
endinterface

// File: rtl/riscv_wbu_regfile.sv
// Writeback unit: ALU writes always win the single register-file write port,
// LSU loads wait in a small FIFO, with forwarding reads, a busy scoreboard
// and a starvation guard that asks issue to hold off ALU ops.
module riscv_wbu_regfile #(
  parameter int LSU_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic                 clock,
  input logic                 reset,
  riscv_wbu_regfile_if.slave  wb
);

  localparam int PTR_W = (LSU_BUF_DEPTH > 1) ? $clog2(LSU_BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [31:0]      regs [32];
  logic [4:0]       fifo_addr [LSU_BUF_DEPTH];
  logic [31:0]      fifo_data [LSU_BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty, push, pop;

  logic             commit_vld, commit_src;
  logic [4:0]       commit_addr;
  logic [31:0]      commit_data;

  logic [STV_W-1:0] starve_cnt, starve_next;
  logic             alu_stall;
  logic [31:0]      busy, busy_next;

  assign fifo_empty    = (count == '0);
  assign wb.lsu_wr_rdy = (count < CNT_W'(LSU_BUF_DEPTH));
  assign push          = wb.lsu_wr_vld && wb.lsu_wr_rdy;

  // Arbitration: ALU first, otherwise drain the FIFO head.
  always_comb begin
    commit_vld  = 1'b0;
    commit_src  = 1'b0;
    commit_addr = '0;
    commit_data = '0;
    pop         = 1'b0;
    if (wb.alu_wr_en) begin
      commit_vld  = 1'b1;
      commit_addr = wb.alu_wr_addr;
      commit_data = wb.alu_wr_data;
    end else if (!fifo_empty) begin
      commit_vld  = 1'b1;
      commit_src  = 1'b1;
      commit_addr = fifo_addr[rd_ptr];
      commit_data = fifo_data[rd_ptr];
      pop         = 1'b1;
    end
  end

  assign wb.commit_vld  = commit_vld;
  assign wb.commit_src  = commit_src;
  assign wb.commit_addr = commit_addr;
  assign wb.commit_data = commit_data;

  // LSU FIFO storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= wb.lsu_wr_addr;
        fifo_data[wr_ptr] <= wb.lsu_wr_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Architectural array; x0 is never written so it always reads 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit_vld && commit_addr != 5'd0) begin
      regs[commit_addr] <= commit_data;
    end
  end

  // Read ports with forwarding from the committing write.
  always_comb begin
    wb.rs1_data = regs[wb.rs1_addr];
    wb.rs2_data = regs[wb.rs2_addr];
    if (commit_vld && commit_addr == wb.rs1_addr && wb.rs1_addr != 5'd0)
      wb.rs1_data = commit_data;
    if (commit_vld && commit_addr == wb.rs2_addr && wb.rs2_addr != 5'd0)
      wb.rs2_data = commit_data;
  end

  // Starvation counter next value: counts ALU-blocked cycles of a waiting head.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty)
      starve_next = '0;
    else if (wb.alu_wr_en && starve_cnt != STV_W'(STARVE_LIMIT))
      starve_next = starve_cnt + STV_W'(1);
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      if (pop)
        alu_stall <= 1'b0;
      else if (starve_next == STV_W'(STARVE_LIMIT))
        alu_stall <= 1'b1;
    end
  end

  assign wb.alu_stall = alu_stall;

  // Scoreboard next value: commit clears, issue set wins, x0 never busy.
  always_comb begin
    busy_next = busy;
    if (commit_vld) busy_next[commit_addr] = 1'b0;
    if (wb.set_busy_en) busy_next[wb.set_busy_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign wb.busy = busy;

endmodule

// File: tb/tb_riscv_wbu_regfile.sv
// Directed bench for the writeback unit and register file.
module tb_riscv_wbu_regfile;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  riscv_wbu_regfile_if bus ();

  riscv_wbu_regfile #(.LSU_BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.alu_wr_en     = 1'b0;
    bus.alu_wr_addr   = '0;
    bus.alu_wr_data   = '0;
    bus.lsu_wr_vld    = 1'b0;
    bus.lsu_wr_addr   = '0;
    bus.lsu_wr_data   = '0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    bus.set_busy_en   = 1'b0;
    bus.set_busy_addr = '0;
  endtask

  task automatic alu(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.alu_wr_en   = en;
    bus.alu_wr_addr = a;
    bus.alu_wr_data = d;
  endtask

  task automatic lsu(input logic vld, input logic [4:0] a, input logic [31:0] d);
    bus.lsu_wr_vld  = vld;
    bus.lsu_wr_addr = a;
    bus.lsu_wr_data = d;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      check_eq({tag, "_rs1"}, bus.rs1_data, 32'h0);
      check_eq({tag, "_rs2"}, bus.rs2_data, 32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state
    check_all_zero("rst_read");
    check_eq("rst_rdy",   {31'b0, bus.lsu_wr_rdy}, 32'h1);
    check_eq("rst_busy",  bus.busy, 32'h0);
    check_eq("rst_stall", {31'b0, bus.alu_stall}, 32'h0);
    check_eq("rst_cvld",  {31'b0, bus.commit_vld}, 32'h0);

    // 2: ALU write with same-cycle forwarding, then x0 write
    alu(1'b1, 5'd5, 32'h12345678);
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd6;
    #1;
    check_eq("alu_fwd",   bus.rs1_data, 32'h12345678);
    check_eq("alu_nofwd", bus.rs2_data, 32'h0);
    check_eq("alu_cvld",  {31'b0, bus.commit_vld}, 32'h1);
    check_eq("alu_csrc",  {31'b0, bus.commit_src}, 32'h0);
    check_eq("alu_caddr", {27'b0, bus.commit_addr}, 32'd5);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("alu_array", bus.rs1_data, 32'h12345678);
    alu(1'b1, 5'd0, 32'hFFFFFFFF);
    bus.rs1_addr = 5'd0;
    #1;
    check_eq("x0_fwd",   bus.rs1_data, 32'h0);
    check_eq("x0_caddr", {27'b0, bus.commit_addr}, 32'd0);
    check_eq("x0_cdata", bus.commit_data, 32'hFFFFFFFF);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("x0_array", bus.rs1_data, 32'h0);

    // 3: LSU pushes with ALU idle
    lsu(1'b1, 5'd3, 32'hA);
    #1;
    check_eq("lsu_nobypass", {31'b0, bus.commit_vld}, 32'h0);
    tick();
    lsu(1'b1, 5'd4, 32'hB);
    #1;
    check_eq("lsu1_vld",  {31'b0, bus.commit_vld}, 32'h1);
    check_eq("lsu1_src",  {31'b0, bus.commit_src}, 32'h1);
    check_eq("lsu1_addr", {27'b0, bus.commit_addr}, 32'd3);
    check_eq("lsu1_data", bus.commit_data, 32'hA);
    tick();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("lsu2_src",  {31'b0, bus.commit_src}, 32'h1);
    check_eq("lsu2_addr", {27'b0, bus.commit_addr}, 32'd4);
    check_eq("lsu2_data", bus.commit_data, 32'hB);
    tick();
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd4;
    #1;
    check_eq("lsu_empty", {31'b0, bus.commit_vld}, 32'h0);
    check_eq("lsu_rdy",   {31'b0, bus.lsu_wr_rdy}, 32'h1);
    check_eq("lsu_x3",    bus.rs1_data, 32'hA);
    check_eq("lsu_x4",    bus.rs2_data, 32'hB);

    // 4: ALU every cycle blocks the LSU; starvation guard
    alu(1'b1, 5'd10, 32'h1000);
    lsu(1'b1, 5'd11, 32'h111);
    #1;
    check_eq("st_c0_rdy", {31'b0, bus.lsu_wr_rdy}, 32'h1);
    tick();
    alu(1'b1, 5'd10, 32'h1001);
    lsu(1'b1, 5'd12, 32'h222);
    #1;
    check_eq("st_c1_rdy", {31'b0, bus.lsu_wr_rdy}, 32'h1);
    check_eq("st_c1_src", {31'b0, bus.commit_src}, 32'h0);
    tick();
    alu(1'b1, 5'd10, 32'h1002);
    lsu(1'b1, 5'd13, 32'h333);
    #1;
    check_eq("st_c2_full", {31'b0, bus.lsu_wr_rdy}, 32'h0);
    tick();
    alu(1'b1, 5'd10, 32'h1003);
    #1;
    check_eq("st_c3_stall", {31'b0, bus.alu_stall}, 32'h0);
    tick();
    alu(1'b1, 5'd10, 32'h1004);
    #1;
    check_eq("st_c4_stall", {31'b0, bus.alu_stall}, 32'h0);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("st_c5_stall", {31'b0, bus.alu_stall}, 32'h1);
    check_eq("st_c5_rdy",   {31'b0, bus.lsu_wr_rdy}, 32'h0);
    check_eq("st_c5_src",   {31'b0, bus.commit_src}, 32'h1);
    check_eq("st_c5_addr",  {27'b0, bus.commit_addr}, 32'd11);
    check_eq("st_c5_data",  bus.commit_data, 32'h111);
    tick();
    #1;
    check_eq("st_c6_stall", {31'b0, bus.alu_stall}, 32'h0);
    check_eq("st_c6_rdy",   {31'b0, bus.lsu_wr_rdy}, 32'h1);
    check_eq("st_c6_addr",  {27'b0, bus.commit_addr}, 32'd12);
    check_eq("st_c6_data",  bus.commit_data, 32'h222);
    tick();
    lsu(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("st_c7_addr", {27'b0, bus.commit_addr}, 32'd13);
    check_eq("st_c7_data", bus.commit_data, 32'h333);
    tick();
    bus.rs1_addr = 5'd10;
    bus.rs2_addr = 5'd12;
    #1;
    check_eq("st_c8_vld", {31'b0, bus.commit_vld}, 32'h0);
    check_eq("st_x10",    bus.rs1_data, 32'h1004);
    check_eq("st_x12",    bus.rs2_data, 32'h222);
    bus.rs1_addr = 5'd11;
    bus.rs2_addr = 5'd13;
    #1;
    check_eq("st_x11", bus.rs1_data, 32'h111);
    check_eq("st_x13", bus.rs2_data, 32'h333);

    // 5: scoreboard
    bus.set_busy_en   = 1'b1;
    bus.set_busy_addr = 5'd7;
    tick();
    check_eq("sb_set7", bus.busy, 32'h0000_0080);
    alu(1'b1, 5'd7, 32'h77);
    tick();
    check_eq("sb_setwins", bus.busy, 32'h0000_0080);
    bus.set_busy_en = 1'b0;
    alu(1'b1, 5'd7, 32'h78);
    tick();
    check_eq("sb_clr7", bus.busy, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    bus.set_busy_en   = 1'b1;
    bus.set_busy_addr = 5'd0;
    tick();
    check_eq("sb_x0", bus.busy, 32'h0);
    bus.set_busy_addr = 5'd9;
    tick();
    bus.set_busy_en = 1'b0;
    alu(1'b1, 5'd3, 32'h33);
    tick();
    check_eq("sb_other", bus.busy, 32'h0000_0200);
    alu(1'b1, 5'd9, 32'h99);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    check_eq("sb_clr9", bus.busy, 32'h0);

    // 6: reset with a full FIFO
    alu(1'b1, 5'd14, 32'hCC);
    lsu(1'b1, 5'd20, 32'hAA);
    tick();
    lsu(1'b1, 5'd21, 32'hBB);
    tick();
    lsu(1'b0, 5'd0, 32'h0);
    bus.set_busy_en   = 1'b1;
    bus.set_busy_addr = 5'd15;
    #1;
    check_eq("rr_full", {31'b0, bus.lsu_wr_rdy}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    check_eq("rr_rdy",   {31'b0, bus.lsu_wr_rdy}, 32'h1);
    check_eq("rr_cvld",  {31'b0, bus.commit_vld}, 32'h0);
    check_eq("rr_busy",  bus.busy, 32'h0);
    check_eq("rr_stall", {31'b0, bus.alu_stall}, 32'h0);
    tick();
    check_eq("rr_cvld2", {31'b0, bus.commit_vld}, 32'h0);
    check_all_zero("rr_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
